// File: rtl/sap_loader_pkg.sv
// sap_loader_pkg -- shared types and defaults for the SAP program loader.
// Optional readback verify is enabled by defining LOADER_VERIFY_EN; without it
// the VFY_* states are not part of the state type at all.
package sap_loader_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_LENGTH = 16;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_BYTE,
    ADDR_SETUP,
    ADDR_PULSE,
    DATA_SETUP,
    DATA_PULSE,
`ifdef LOADER_VERIFY_EN
    VFY_SETUP,
    VFY_CHECK,
`endif
    DONE
  } state_e;

  // Single-bit control outputs, all registered together in the top.
  typedef struct packed {
    logic in_ready;
    logic bus_drive;
    logic maddr_latch;
    logic ram_latch;
    logic ram_out;
    logic ram_clk_pulse;
    logic busy;
    logic done;
  } ctrl_t;

  // Control values that belong to a given state.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      WAIT_BYTE:  c.in_ready = 1'b1;
      ADDR_SETUP: begin
        c.bus_drive   = 1'b1;
        c.maddr_latch = 1'b1;
      end
      ADDR_PULSE: begin
        c.bus_drive     = 1'b1;
        c.maddr_latch   = 1'b1;
        c.ram_clk_pulse = 1'b1;
      end
      DATA_SETUP: begin
        c.bus_drive = 1'b1;
        c.ram_latch = 1'b1;
      end
      DATA_PULSE: begin
        c.bus_drive     = 1'b1;
        c.ram_latch     = 1'b1;
        c.ram_clk_pulse = 1'b1;
      end
`ifdef LOADER_VERIFY_EN
      VFY_SETUP:  c.ram_out = 1'b1;
      VFY_CHECK: begin
        c.ram_out       = 1'b1;
        c.ram_clk_pulse = 1'b1;
      end
`endif
      DONE:       c.done = 1'b1;
      default:    ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sap_loader_addr_counter.sv
// sap_loader_addr_counter -- RAM address counter for the program loader.
// Clears to 0, increments on request, and saturates at LENGTH-1 so a run can
// never wrap back over already-written words.
module sap_loader_addr_counter #(
  parameter int ADDR_W = 4,
  parameter int LENGTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              incr_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LENGTH - 1);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;

  // Next count: clear wins over increment; hold at the terminal value.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d (no latch).
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i && (count_q != LAST_ADDR)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST_ADDR);

endmodule

// File: rtl/sap_program_loader.sv
// sap_program_loader -- streams LENGTH program bytes into the SAP RAM over the
// W bus while holding the CPU. Each byte: latch address, write data, and with
// LOADER_VERIFY_EN defined, read the word back and flag a mismatch in error.
// All outputs are registered and cleared asynchronously by reset.
module sap_program_loader
  import sap_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LENGTH = DEF_LENGTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              bus_drive,
  output logic [DATA_W-1:0] bus_data,
  input  logic [DATA_W-1:0] bus_in,
  output logic              maddr_latch,
  output logic              ram_latch,
  output logic              ram_out,
  output logic              ram_clk_pulse,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // The state after which the next address is chosen or the run ends.
`ifdef LOADER_VERIFY_EN
  localparam state_e LAST_WR_STATE = VFY_CHECK;
`else
  localparam state_e LAST_WR_STATE = DATA_PULSE;
`endif

  state_e            state_q;
  state_e            state_d;
  ctrl_t             ctrl_q;
  ctrl_t             ctrl_d;
  logic [DATA_W-1:0] bus_data_q;
  logic [DATA_W-1:0] bus_data_d;
  logic [DATA_W-1:0] byte_q;

  logic              accept;
  logic              addr_clear;
  logic              addr_incr;
  logic              addr_last;
  logic [ADDR_W-1:0] addr;

  assign accept     = (state_q == WAIT_BYTE) && in_valid;
  assign addr_clear = (state_q == IDLE) && start;
  assign addr_incr  = (state_q == LAST_WR_STATE) && !addr_last;

  sap_loader_addr_counter #(
    .ADDR_W (ADDR_W),
    .LENGTH (LENGTH)
  ) u_addr_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (addr_clear),
    .incr_i  (addr_incr),
    .count_o (addr),
    .last_o  (addr_last)
  );

  // Next state and the registered control/bus values that go with it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start) state_d = WAIT_BYTE;
      WAIT_BYTE:  if (in_valid) state_d = ADDR_SETUP;
      ADDR_SETUP: state_d = ADDR_PULSE;
      ADDR_PULSE: state_d = DATA_SETUP;
      DATA_SETUP: state_d = DATA_PULSE;
`ifdef LOADER_VERIFY_EN
      DATA_PULSE: state_d = VFY_SETUP;
      VFY_SETUP:  state_d = VFY_CHECK;
      VFY_CHECK:  state_d = addr_last ? DONE : WAIT_BYTE;
`else
      DATA_PULSE: state_d = addr_last ? DONE : WAIT_BYTE;
`endif
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    ctrl_d = decode_ctrl(state_d);

    // The counter only moves when leaving the last write state, so it is
    // already stable when the address phase is entered.
    bus_data_d = '0;
    if ((state_d == ADDR_SETUP) || (state_d == ADDR_PULSE)) begin
      bus_data_d = DATA_W'(addr);
    end else if ((state_d == DATA_SETUP) || (state_d == DATA_PULSE)) begin
      bus_data_d = byte_q;
    end
  end

  // FSM state, registered outputs and the captured program byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      bus_data_q <= '0;
      byte_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      bus_data_q <= bus_data_d;
      if (accept) begin
        byte_q <= in_data;
      end
    end
  end

`ifdef LOADER_VERIFY_EN
  logic error_q;

  // Sticky readback mismatch; cleared only by an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (addr_clear) begin
      error_q <= 1'b0;
    end else if ((state_q == VFY_CHECK) && (bus_in != byte_q)) begin
      error_q <= 1'b1;
    end
  end

  assign error   = error_q;
  assign ram_out = ctrl_q.ram_out;
`else
  // Readback path absent: the W-bus input is intentionally ignored.
  logic unused_bus_in;
  logic unused_ram_out;
  assign unused_bus_in  = ^bus_in;
  assign unused_ram_out = ctrl_q.ram_out;
  assign error          = 1'b0;
  assign ram_out        = 1'b0;
`endif

  assign in_ready      = ctrl_q.in_ready;
  assign bus_drive     = ctrl_q.bus_drive;
  assign bus_data      = bus_data_q;
  assign maddr_latch   = ctrl_q.maddr_latch;
  assign ram_latch     = ctrl_q.ram_latch;
  assign ram_clk_pulse = ctrl_q.ram_clk_pulse;
  assign busy          = ctrl_q.busy;
  assign cpu_hold      = ctrl_q.busy;
  assign done          = ctrl_q.done;

endmodule

// File: tb/tb_sap_program_loader.sv
// tb_sap_program_loader -- randomized self-checking bench for the program
// loader. A behavioural RAM (address register + word array) is clocked by the
// loader's pulse; expected images come from the byte list fed in.
// Build with LOADER_VERIFY_EN defined to exercise the readback path.
module tb_sap_program_loader;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int LENGTH  = 16;
  localparam int MAX_CYC = 3000;
`ifdef LOADER_VERIFY_EN
  localparam int EXP_LAT = 7;
`else
  localparam int EXP_LAT = 5;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              bus_drive;
  logic [DATA_W-1:0] bus_data;
  logic [DATA_W-1:0] bus_in;
  logic              maddr_latch;
  logic              ram_latch;
  logic              ram_out;
  logic              ram_clk_pulse;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  sap_program_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LENGTH (LENGTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .bus_drive     (bus_drive),
    .bus_data      (bus_data),
    .bus_in        (bus_in),
    .maddr_latch   (maddr_latch),
    .ram_latch     (ram_latch),
    .ram_out       (ram_out),
    .ram_clk_pulse (ram_clk_pulse),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural RAM: address register and word array, read combinationally.
  logic [DATA_W-1:0] mem [LENGTH];
  logic [ADDR_W-1:0] mar = '0;
  int                corrupt_addr = -1;

  assign bus_in = ram_out ? ((int'(mar) == corrupt_addr) ? 8'hFF : mem[mar]) : 8'h00;

  // Stimulus data and observation state shared with the monitor.
  logic [DATA_W-1:0] feed [$];
  int                feed_idx = 0;
  int                wr_q [$];
  int                cyc = 0;
  int                acc_cnt = 0;
  int                acc_cyc = 0;
  int                done_cnt = 0;
  int                viol = 0;
  int                err_first_wr = -1;
  logic              err_at_done = 1'b0;
  bit                lat_pend = 1'b0;

  // Monitor on the falling edge: protocol rules, RAM model, latency.
  always @(negedge clk) begin
    cyc++;
    if ($countones({maddr_latch, ram_latch, ram_out}) > 1) viol++;
    if (bus_drive && ram_out) viol++;
    if (busy !== cpu_hold) viol++;
    if (in_ready && (bus_drive || maddr_latch || ram_latch || ram_out ||
                     ram_clk_pulse || done || !busy)) viol++;
    if (reset || !busy) begin
      lat_pend = 1'b0;
    end else if (in_ready && lat_pend) begin
      check("accept_to_ready_latency", cyc - acc_cyc, EXP_LAT);
      lat_pend = 1'b0;
    end
    if (in_valid && in_ready) begin
      acc_cnt++;
      feed_idx++;
      acc_cyc  = cyc;
      lat_pend = 1'b1;
    end
    if (ram_clk_pulse && maddr_latch) mar = bus_data[ADDR_W-1:0];
    if (ram_clk_pulse && ram_latch) begin
      mem[mar] = bus_data;
      wr_q.push_back(int'(mar));
      if (wr_q.size() > acc_cnt) viol++;
    end
    if (error && (err_first_wr < 0)) err_first_wr = wr_q.size();
    if (done) begin
      done_cnt++;
      err_at_done = error;
    end
  end

  function automatic logic [31:0] outs_vec();
    return {14'd0, in_ready, bus_drive, maddr_latch, ram_latch, ram_out,
            ram_clk_pulse, cpu_hold, busy, done, error, bus_data};
  endfunction

  // One load run. vmode: 0 valid always, 1 toggling, 2 random.
  // start_at >= 0 re-pulses start once that many bytes are accepted;
  // rst_at >= 0 asserts reset inside the write pulse of that address.
  task automatic run_load(input int vmode, input int start_at, input int rst_at, output bit hit);
    int d0;
    bit fin;
    bit pulsed;
    hit          = 1'b0;
    fin          = 1'b0;
    pulsed       = 1'b0;
    feed_idx     = 0;
    acc_cnt      = 0;
    err_first_wr = -1;
    wr_q.delete();
    d0 = done_cnt;
    for (int a = 0; a < LENGTH; a++) mem[a] = 8'hAA;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; (c < MAX_CYC) && !fin; c++) begin
      if (feed_idx < LENGTH) begin
        in_data  = feed[feed_idx];
        in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? c[0] : 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      start = (start_at >= 0) && !pulsed && (feed_idx == start_at);
      if (start) pulsed = 1'b1;
      @(negedge clk);
      #1;
      if ((rst_at >= 0) && ram_clk_pulse && ram_latch && (int'(mar) == rst_at)) begin
        reset = 1'b1;
        #1;
        hit = 1'b1;
        fin = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (done_cnt != d0) fin = 1'b1;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("run_finished_in_budget", 32'(fin), 1);
  endtask

  // Expected image: the first n fed bytes, untouched fill elsewhere.
  task automatic check_image(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < LENGTH; i++) begin
      check($sformatf("ram_word_%0d", i), 32'(mem[i]), (i < n) ? 32'(feed[i]) : 32'h0000_00AA);
    end
    foreach (wr_q[i]) if (wr_q[i] != i) bad++;
    check("write_address_order_errors", bad, 0);
    check("write_count", wr_q.size(), n);
  endtask

  task automatic full_run_checks(input int d0);
    tick();
    check_image(LENGTH);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after_run", 32'(busy), 0);
    check("cpu_hold_after_run", 32'(cpu_hold), 0);
  endtask

  task automatic make_random_feed();
    feed.delete();
    for (int i = 0; i < LENGTH; i++) feed.push_back(8'($urandom));
  endtask

  initial begin
    bit hit;
    int d0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) tick();
    check("outputs_in_reset", outs_vec(), 0);
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 0);

    // Incrementing bytes, in_valid held high.
    feed.delete();
    for (int i = 0; i < LENGTH; i++) feed.push_back(8'(8'h10 + i));
    d0 = done_cnt;
    run_load(0, -1, -1, hit);
    full_run_checks(d0);
    check("error_clean_run", 32'(err_at_done), 0);

    // Same bytes, in_valid toggling every cycle.
    d0 = done_cnt;
    run_load(1, -1, -1, hit);
    full_run_checks(d0);

    // Random bytes, random in_valid, start re-pulsed at address 5.
    make_random_feed();
    d0 = done_cnt;
    run_load(2, 5, -1, hit);
    full_run_checks(d0);

    // Reset inside the write pulse of address 7.
    make_random_feed();
    d0 = done_cnt;
    run_load(0, -1, 7, hit);
    check("reset_point_reached", 32'(hit), 1);
    check("outputs_after_midrun_reset", outs_vec(), 0);
    check_image(8);
    check("no_done_after_reset", done_cnt - d0, 0);
    tick();
    reset = 1'b0;
    tick();
    check("idle_after_reset", 32'(busy), 0);

    // Full random run after the aborted one.
    make_random_feed();
    d0 = done_cnt;
    run_load(2, -1, -1, hit);
    full_run_checks(d0);

`ifdef LOADER_VERIFY_EN
    // Readback of address 3 returns 0xFF while the written byte differs.
    make_random_feed();
    feed[3]      = 8'($urandom_range(0, 8'hFE));
    corrupt_addr = 3;
    d0           = done_cnt;
    run_load(0, -1, -1, hit);
    corrupt_addr = -1;
    check("error_rises_after_addr3_check", err_first_wr, 4);
    check("error_at_done", 32'(err_at_done), 1);
    full_run_checks(d0);
    check("error_sticky_in_idle", 32'(error), 1);

    // A clean run after it: error must clear at start and stay low.
    make_random_feed();
    d0 = done_cnt;
    run_load(2, -1, -1, hit);
    check("error_cleared_by_start", err_first_wr, 32'hFFFF_FFFF);
    check("error_at_done_clean", 32'(err_at_done), 0);
    full_run_checks(d0);
`endif

    check("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sap_program_loader.md
SAP_PROGRAM_LOADER -- requirements
Module: sap_program_loader

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 4, RAM address width.
- DATA_W, default 8, W-bus and RAM word width.
- LENGTH, default 16, number of words loaded per run (1..2**ADDR_W).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high.
- start, in, 1: begin a load run.
- in_valid, in, 1: input byte available.
- in_data, in, DATA_W: program byte.
- in_ready, out, 1: loader accepts the byte this cycle.
- bus_drive, out, 1: top drives bus_data onto the W bus when high.
- bus_data, out, DATA_W: address or data value for the W bus.
- bus_in, in, DATA_W: W-bus value, used for readback only.
- maddr_latch, out, 1: RAM address-register latch control.
- ram_latch, out, 1: RAM write control.
- ram_out, out, 1: RAM output enable, readback only.
- ram_clk_pulse, out, 1: one-cycle clock pulse that top muxes onto the RAM clock while busy.
- cpu_hold, out, 1: high while busy; top gates the CPU clock and holds the program counter.
- busy, out, 1: run in progress.
- done, out, 1: one-cycle pulse at the end of a run.
- error, out, 1: sticky readback mismatch flag.

Function
REQ-003 The FSM states SHALL be IDLE, WAIT_BYTE, ADDR_SETUP, ADDR_PULSE, DATA_SETUP, DATA_PULSE, VFY_SETUP, VFY_CHECK, DONE.
REQ-004 IDLE SHALL go to WAIT_BYTE on start=1, clear the address counter to 0, and clear error.
REQ-005 start SHALL be ignored in every state other than IDLE.
REQ-006 in_ready SHALL be 1 only in WAIT_BYTE.
REQ-007 A byte SHALL be accepted when in_valid and in_ready are both high; the accepted byte is captured and the FSM goes to ADDR_SETUP.
REQ-008 In ADDR_SETUP and ADDR_PULSE, outputs SHALL be bus_drive=1, bus_data=zero-extended address, maddr_latch=1.
REQ-009 ram_clk_pulse SHALL be 1 only in ADDR_PULSE, DATA_PULSE and VFY_CHECK.
REQ-010 In DATA_SETUP and DATA_PULSE, outputs SHALL be bus_drive=1, bus_data=captured byte, ram_latch=1.
REQ-011 In VFY_SETUP and VFY_CHECK, outputs SHALL be bus_drive=0 and ram_out=1.
REQ-012 In VFY_CHECK, bus_in not equal to the captured byte SHALL set error; error stays set until the next accepted start.
REQ-013 maddr_latch, ram_latch and ram_out SHALL be one-hot or all zero.
REQ-014 bus_drive SHALL never be 1 while ram_out is 1.
REQ-015 After the last write state, if address = LENGTH-1 the FSM SHALL go to DONE; otherwise it increments the address and returns to WAIT_BYTE.
REQ-016 The address SHALL never wrap during a run.
REQ-017 DONE SHALL last one cycle with done=1 and then go to IDLE.
REQ-018 busy and cpu_hold SHALL be 1 in every state except IDLE.
REQ-019 Latency from byte acceptance to the next in_ready SHALL be 5 cycles without verify and 7 cycles with verify.
REQ-020 in_valid low in WAIT_BYTE SHALL stall indefinitely with all controls 0.

Reset
REQ-021 Asserting reset SHALL force IDLE, address 0, and all outputs 0 (including error), including mid-run.
REQ-022 A mid-run reset SHALL drop bus_drive within the same cycle and leave a partial RAM image.

Configuration
REQ-023 With LOADER_VERIFY_EN defined, DATA_PULSE SHALL proceed to VFY_SETUP then VFY_CHECK, and readback runs per REQ-011 and REQ-012.
REQ-024 Without LOADER_VERIFY_EN, the VFY states SHALL not exist, DATA_PULSE proceeds directly per REQ-015, ram_out ties to 0, error ties to 0, and bus_in is unused.

Structure
REQ-025 Package sap_loader_pkg SHALL hold the state enum and the default ADDR_W/DATA_W/LENGTH constants.
REQ-026 One sub-module, sap_loader_addr_counter (clear, increment, terminal-count flag), SHALL hold the address counter; everything else stays flat.

Verification
REQ-027 The bench SHALL cover these scenarios:
- LENGTH=16; start, then stream bytes 0x10..0x1F with in_valid always 1 -> RAM[i]=0x10+i, one done pulse, busy low afterwards, 16 writes total.
- in_valid toggled 1/0 each cycle -> in_ready only in WAIT_BYTE; no write until a byte is accepted; final image identical to the previous scenario.
- start pulsed again mid-run at address 5 -> ignored; address sequence remains 0..15.
- reset asserted during DATA_PULSE at address 7 -> all outputs 0 the same cycle; RAM[0..6] written; RAM[7] unwritten or complete.
- LOADER_VERIFY_EN defined, RAM model corrupts address 3 to 0xFF -> error=1 after VFY_CHECK of address 3 and still 1 at done; a following start clears it.
- Every cycle, assertions hold: at most one of maddr_latch/ram_latch/ram_out is high; bus_drive and ram_out are never both high.
